// File: rtl/addsub_share_arbiter.sv
// Round-robin arbiter sharing one WIDTH-bit add/subtract datapath among NREQ requesters.
// Latency 1 cycle from accept to rsp_valid; a held response stalls all grants until rsp_ready.
module addsub_share_arbiter #(
    parameter int WIDTH = 8,
    parameter int NREQ  = 4,
    parameter int IDW   = 2
) (
    input  logic                  CLK,
    input  logic                  RESETN,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ-1:0]       req_op,
    input  logic [NREQ*WIDTH-1:0] req_z,
    input  logic [NREQ*WIDTH-1:0] req_x,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [WIDTH-1:0]      rsp_a,
    output logic                  rsp_cout,
    output logic [IDW-1:0]        rsp_id,
    output logic [15:0]           ops_count
);

    logic             vld_q, vld_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic             cout_q, cout_d;
    logic [IDW-1:0]   id_q, id_d;
    logic [15:0]      cnt_q, cnt_d;
    logic [IDW-1:0]   ptr_q, ptr_d;

    logic             free;
    logic             grant_vld;
    logic [IDW-1:0]   grant_idx;
    logic [IDW-1:0]   cand;
    logic             accept;
    logic [WIDTH-1:0] z_sel, x_sel;
    logic             op_sel;
    logic [WIDTH:0]   sum;

    assign free = !vld_q || rsp_ready;

    // Scan from the farthest candidate back to ptr so the nearest valid one wins.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            cand = IDW'((int'(ptr_q) + k) % NREQ);
            if (req_valid[cand]) begin
                grant_vld = 1'b1;
                grant_idx = cand;
            end
        end
    end

    assign accept    = RESETN && free && grant_vld;
    assign req_ready = accept ? (NREQ'(1) << grant_idx) : '0;

    assign z_sel  = req_z[grant_idx*WIDTH +: WIDTH];
    assign x_sel  = req_x[grant_idx*WIDTH +: WIDTH];
    assign op_sel = req_op[grant_idx];
    // Subtract as z + ~x + 1 so carry out doubles as the no-borrow flag.
    assign sum    = {1'b0, z_sel} + {1'b0, (op_sel ? ~x_sel : x_sel)} + {{WIDTH{1'b0}}, op_sel};

    always_comb begin
        vld_d  = vld_q;
        a_d    = a_q;
        cout_d = cout_q;
        id_d   = id_q;
        cnt_d  = cnt_q;
        ptr_d  = ptr_q;
        if (accept) begin
            vld_d  = 1'b1;
            a_d    = sum[WIDTH-1:0];
            cout_d = sum[WIDTH];
            id_d   = grant_idx;
            ptr_d  = (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
            cnt_d  = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
        end else if (rsp_ready) begin
            vld_d  = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            vld_q  <= 1'b0;
            a_q    <= '0;
            cout_q <= 1'b0;
            id_q   <= '0;
            cnt_q  <= '0;
            ptr_q  <= '0;
        end else begin
            vld_q  <= vld_d;
            a_q    <= a_d;
            cout_q <= cout_d;
            id_q   <= id_d;
            cnt_q  <= cnt_d;
            ptr_q  <= ptr_d;
        end
    end

    assign rsp_valid = vld_q;
    assign rsp_a     = a_q;
    assign rsp_cout  = cout_q;
    assign rsp_id    = id_q;
    assign ops_count = cnt_q;

endmodule

// File: tb/tb_addsub_share_arbiter.sv
// Self-checking bench: vector table, directed corner sequences and a randomized run against a reference model.
module tb_addsub_share_arbiter;
    localparam int W  = 8;
    localparam int NR = 4;
    localparam int IW = 2;

    logic            CLK = 1'b0;
    logic            RESETN;
    logic [NR-1:0]   req_valid, req_ready, req_op;
    logic [NR*W-1:0] req_z, req_x;
    logic            rsp_valid, rsp_ready, rsp_cout;
    logic [W-1:0]    rsp_a;
    logic [IW-1:0]   rsp_id;
    logic [15:0]     ops_count;

    addsub_share_arbiter #(.WIDTH(W), .NREQ(NR), .IDW(IW)) dut (
        .CLK(CLK), .RESETN(RESETN), .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_z(req_z), .req_x(req_x), .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready), .rsp_a(rsp_a), .rsp_cout(rsp_cout), .rsp_id(rsp_id),
        .ops_count(ops_count)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int fails  = 0;

    // Reference model state
    int m_vld, m_a, m_cout, m_id, m_cnt, m_ptr, m_last_g;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: compare every output to the model at negedge, then advance the model.
    task automatic tick();
        int g;
        int zz, xx, op;
        logic [NR-1:0] exp_rdy;
        @(negedge CLK);
        g = -1;
        exp_rdy = '0;
        if (RESETN && (m_vld == 0 || rsp_ready)) begin
            for (int k = 0; k < NR; k++) begin
                int i;
                i = (m_ptr + k) % NR;
                if (req_valid[i] && g < 0) g = i;
            end
        end
        if (g >= 0) exp_rdy[g] = 1'b1;
        chk("req_ready", 32'(req_ready), 32'(exp_rdy));
        chk("rsp_valid", 32'(rsp_valid), 32'(m_vld));
        chk("rsp_a", 32'(rsp_a), 32'(m_a));
        chk("rsp_cout", 32'(rsp_cout), 32'(m_cout));
        chk("rsp_id", 32'(rsp_id), 32'(m_id));
        chk("ops_count", 32'(ops_count), 32'(m_cnt));
        m_last_g = -1;
        if (!RESETN) begin
            m_vld = 0; m_a = 0; m_cout = 0; m_id = 0; m_cnt = 0; m_ptr = 0;
        end else if (g >= 0) begin
            zz = int'(req_z[g*W +: W]);
            xx = int'(req_x[g*W +: W]);
            op = int'(req_op[g]);
            if (op == 0) begin
                m_a    = (zz + xx) % 256;
                m_cout = (zz + xx >= 256) ? 1 : 0;
            end else begin
                m_a    = (zz - xx + 256) % 256;
                m_cout = (zz >= xx) ? 1 : 0;
            end
            m_vld = 1;
            m_id  = g;
            m_ptr = (g + 1) % NR;
            if (m_cnt < 65535) m_cnt++;
            m_last_g = g;
        end else if (rsp_ready) begin
            m_vld = 0;
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RESETN = 1'b0;
        tick();
        tick();
        RESETN = 1'b1;
    endtask

    typedef struct {
        logic         op;
        logic [W-1:0] z;
        logic [W-1:0] x;
        logic [W-1:0] exp_a;
        logic         exp_cout;
    } vec_t;

    vec_t vecs[8];
    logic [W-1:0] held_a;
    logic [IW-1:0] held_id;

    initial begin
        vecs[0] = '{1'b0, 8'h12, 8'h34, 8'h46, 1'b0};
        vecs[1] = '{1'b1, 8'h05, 8'h07, 8'hFE, 1'b0};
        vecs[2] = '{1'b1, 8'h07, 8'h05, 8'h02, 1'b1};
        vecs[3] = '{1'b0, 8'hFF, 8'h01, 8'h00, 1'b1};
        vecs[4] = '{1'b1, 8'h00, 8'h01, 8'hFF, 1'b0};
        vecs[5] = '{1'b0, 8'h80, 8'h80, 8'h00, 1'b1};
        vecs[6] = '{1'b1, 8'h33, 8'h33, 8'h00, 1'b1};
        vecs[7] = '{1'b0, 8'h7F, 8'h01, 8'h80, 1'b0};

        m_vld = 0; m_a = 0; m_cout = 0; m_id = 0; m_cnt = 0; m_ptr = 0; m_last_g = -1;
        req_valid = '1; req_op = '0; req_z = '0; req_x = '0; rsp_ready = 1'b1;

        // Reset with every requester asserting
        RESETN = 1'b0;
        tick();
        tick();
        chk("rst_req_ready", 32'(req_ready), 32'h0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("rst_ops_count", 32'(ops_count), 32'h0);
        RESETN = 1'b1;
        #1;
        chk("rst_first_grant", 32'(req_ready), 32'h1);

        // Vector table through requester 0
        do_reset();
        req_valid = '0;
        for (int v = 0; v < 8; v++) begin
            req_valid = 4'b0001;
            req_op[0] = vecs[v].op;
            req_z[0 +: W] = vecs[v].z;
            req_x[0 +: W] = vecs[v].x;
            tick();
            req_valid = '0;
            chk("vec_valid", 32'(rsp_valid), 32'h1);
            chk("vec_a", 32'(rsp_a), 32'(vecs[v].exp_a));
            chk("vec_cout", 32'(rsp_cout), 32'(vecs[v].exp_cout));
            chk("vec_id", 32'(rsp_id), 32'h0);
            tick();
        end

        // Round-robin with all requesters valid
        do_reset();
        req_valid = '1;
        rsp_ready = 1'b1;
        for (int n = 0; n < 5; n++) begin
            tick();
            chk("rr_id", 32'(rsp_id), 32'(n % 4));
            chk("rr_valid", 32'(rsp_valid), 32'h1);
            chk("rr_count", 32'(ops_count), 32'(n + 1));
        end

        // Backpressure: id 0 is held, ptr now 1
        rsp_ready = 1'b0;
        held_a  = rsp_a;
        held_id = rsp_id;
        for (int n = 0; n < 5; n++) begin
            tick();
            chk("bp_valid", 32'(rsp_valid), 32'h1);
            chk("bp_a", 32'(rsp_a), 32'(held_a));
            chk("bp_id", 32'(rsp_id), 32'(held_id));
            chk("bp_ready", 32'(req_ready), 32'h0);
        end
        rsp_ready = 1'b1;
        #1;
        chk("bp_release_grant", 32'(req_ready), 32'h2);
        tick();
        chk("bp_next_id", 32'(rsp_id), 32'h1);
        chk("bp_count", 32'(ops_count), 32'h6);

        // Sparse requests
        do_reset();
        req_valid = 4'b0010;
        tick();
        chk("sparse_id1", 32'(rsp_id), 32'h1);
        req_valid = 4'b1010;
        #1;
        chk("sparse_ready3", 32'(req_ready), 32'h8);
        tick();
        chk("sparse_id3", 32'(rsp_id), 32'h3);
        req_valid = '0;
        tick();
        chk("drain_valid", 32'(rsp_valid), 32'h0);
        chk("drain_keep_id", 32'(rsp_id), 32'h3);

        // Randomized traffic, requests held until accepted, occasional mid-run reset
        do_reset();
        for (int i = 0; i < NR; i++) begin
            req_valid[i] = 1'($urandom_range(0, 1));
            req_op[i] = 1'($urandom_range(0, 1));
            req_z[i*W +: W] = W'($urandom);
            req_x[i*W +: W] = W'($urandom);
        end
        for (int n = 0; n < 400; n++) begin
            rsp_ready = ($urandom_range(0, 3) != 0);
            RESETN = ($urandom_range(0, 60) != 0);
            tick();
            for (int i = 0; i < NR; i++) begin
                if (!req_valid[i] || i == m_last_g) begin
                    req_valid[i] = 1'($urandom_range(0, 1));
                    req_op[i] = 1'($urandom_range(0, 1));
                    req_z[i*W +: W] = W'($urandom);
                    req_x[i*W +: W] = W'($urandom);
                end
            end
        end
        RESETN = 1'b1;

        // Saturation of the operation counter
        do_reset();
        req_valid = 4'b0001;
        rsp_ready = 1'b1;
        repeat (65536) tick();
        chk("sat_count", 32'(ops_count), 32'hFFFF);
        tick();
        chk("sat_hold", 32'(ops_count), 32'hFFFF);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule

// File: doc/addsub_share_arbiter.md
Name: addsub_share_arbiter

Overview:
- Shares one WIDTH-bit add/subtract datapath (a = z + x + cin; subtract computed as z + ~x + 1) among NREQ requesters.
- Round-robin arbitration, one operation accepted per cycle, result held in a single registered response slot with valid/ready handshake.
- Sits between multiple client blocks and the shared adder; the adder itself stays combinational inside this block.

Parameters:
- WIDTH, 8, operand/result width in bits
- NREQ, 4, number of requesters (2..8)
- IDW, 2, width of requester id; must satisfy 2^IDW >= NREQ

Ports:
- CLK  input  1  clock; all state updates on rising edge
- RESETN  input  1  synchronous active-low reset
- req_valid  input  NREQ  per-requester request valid
- req_ready  output  NREQ  per-requester accept; at most one bit high per cycle
- req_op  input  NREQ  per-requester opcode: 0 = add, 1 = subtract
- req_z  input  NREQ*WIDTH  first operands, requester i at bits [i*WIDTH +: WIDTH]
- req_x  input  NREQ*WIDTH  second operands, same packing
- rsp_valid  output  1  response slot holds a result
- rsp_ready  input  1  consumer takes result when high with rsp_valid
- rsp_a  output  WIDTH  result, truncated to WIDTH
- rsp_cout  output  1  carry out of the WIDTH-bit add (for subtract: 1 = no borrow)
- rsp_id  output  IDW  index of requester that issued the result
- ops_count  output  16  number of accepted operations, saturating

Behaviour:
- Reset (RESETN low at rising edge): rsp_valid=0, rsp_a=0, rsp_cout=0, rsp_id=0, ops_count=0, rr pointer=0. req_ready is 0 while RESETN is low. Reset mid-operation discards the held response; there is no partial state.
- Slot free: free = !rsp_valid || rsp_ready.
- Arbitration (combinational):
  - When free, the grant goes to the first i with req_valid[i]=1, scanning ptr, ptr+1, ... modulo NREQ.
  - req_ready[g]=1 only for the granted index; all others 0.
  - When not free, req_ready is all 0.
  - req_ready may depend combinationally on req_valid and rsp_ready. A requester must hold valid and operands stable until accepted.
- Accept: req_valid[g] && req_ready[g]. On the next edge:
  - rsp_valid=1, rsp_id=g.
  - {rsp_cout, rsp_a} = z + (op ? ~x : x) + op, computed in WIDTH+1 bits.
  - ptr = (g+1) mod NREQ.
  - ops_count increments, saturating at 0xFFFF.
- Latency is 1 cycle from accept to rsp_valid. Throughput is 1 op/cycle while rsp_ready is held high (a response leaves and a new one loads on the same edge).
- No accept but rsp_valid && rsp_ready: rsp_valid becomes 0 on the next edge. rsp_a, rsp_cout and rsp_id keep their last values.
- Backpressure: rsp_valid && !rsp_ready holds rsp_a, rsp_cout and rsp_id stable. No grants occur and ptr does not move.
- No valid requests: no grant, ptr unchanged.
- Wrap-around: arithmetic is modulo 2^WIDTH. For example, 0xFF + 0x01 gives a=0x00, cout=1. Subtract 0x00 - 0x01 gives a=0xFF, cout=0.
- Fairness: any continuously asserting requester is granted within NREQ accepts.

Test Plan:
- Reset: hold RESETN=0 for 2 cycles with all req_valid=1 -> req_ready=0, rsp_valid=0, ops_count=0. Release -> requester 0 is granted first.
- Single add: req0 op=0, z=0x12, x=0x34 -> next cycle rsp_valid=1, rsp_a=0x46, rsp_cout=0, rsp_id=0. Subtract req0 z=0x05, x=0x07 -> rsp_a=0xFE, rsp_cout=0. Repeat with z=0x07, x=0x05 -> rsp_a=0x02, rsp_cout=1.
- Round-robin: all four valid continuously, rsp_ready=1 -> rsp_id sequence 0,1,2,3,0, one result per cycle. ops_count increments by 1 each cycle.
- Backpressure: rsp_ready=0 for 5 cycles with a result held -> rsp_a, rsp_id and rsp_valid stable, req_ready=0. Raise rsp_ready -> the held result drains and the next grant is accepted in the same cycle.
- Sparse requests: ptr=2, only req1 valid -> req1 granted. Next grant search starts at 2, so with req1 and req3 both valid, req3 is granted first.
- Overflow and saturation: z=0xFF, x=0x01 add -> rsp_a=0x00, rsp_cout=1. Force 65536 accepts -> ops_count stays 0xFFFF.
